// File: rtl/store_cntrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : store_cntrl
//  Description : MEM-stage store unit. Accepts a byte/half/word store, builds
//                a word-aligned write (byte enables + lane-shifted data) and
//                issues it to data memory over a req/gnt handshake. Stores
//                that cross a word boundary are split into two word writes,
//                or rejected when SPLIT_MISALIGNED is 0.
//  Ports       : clk_i, rst_ni           clock, async active-low reset
//                st_valid_i/st_ready_o   store handshake from the pipeline
//                st_addr_i/st_data_i     byte address, LSB-justified data
//                st_size_i               00 byte, 01 half, 10 word, 11 bad
//                dmem_req_o/dmem_gnt_i   memory request handshake
//                dmem_we_o/addr/be/wdata write request fields
//                st_done_o/st_err_o      completion / rejection pulses
//                busy_o                  pipeline stall
//  Revision    : 1.0 - initial release
// ============================================================================
module store_cntrl #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_size_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    output logic        st_done_o,
    output logic        st_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_LO = 2'd1,
        S_REQ_HI = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [29:0] r_word_addr;
    logic [7:0]  r_wide_be;
    logic [63:0] r_wide_d;
    logic        r_done;
    logic        r_err;

    logic [3:0]  w_mask;
    logic [7:0]  w_wide_be;
    logic [63:0] w_wide_d;
    logic        w_split;
    logic        w_accept;
    logic        w_reject;
    logic        w_r_split;
    logic [29:0] w_word_addr_hi;
    logic        w_final_gnt;

    always_comb begin
        w_mask = 4'b0000;
        case (st_size_i)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    // Lane placement over an 8-byte window: the upper half is the spill
    // into the next word for boundary-crossing stores.
    assign w_wide_be = {4'b0000, w_mask} << st_addr_i[1:0];
    assign w_wide_d  = {32'h0, st_data_i} << {st_addr_i[1:0], 3'b000};
    assign w_split   = |w_wide_be[7:4];

    assign w_accept  = st_valid_i && (r_state == S_IDLE);
    assign w_reject  = (st_size_i == 2'b11) || (w_split && !SPLIT_MISALIGNED);

    assign w_r_split      = |r_wide_be[7:4];
    // 30-bit word index wraps naturally at the top of the address space.
    assign w_word_addr_hi = r_word_addr + 30'd1;

    assign w_final_gnt = dmem_gnt_i &&
                         (((r_state == S_REQ_LO) && !w_r_split) ||
                          (r_state == S_REQ_HI));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_reject) w_state_nxt = S_REQ_LO;
            S_REQ_LO: if (dmem_gnt_i) w_state_nxt = w_r_split ? S_REQ_HI : S_IDLE;
            S_REQ_HI: if (dmem_gnt_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_word_addr <= 30'h0;
            r_wide_be   <= 8'h0;
            r_wide_d    <= 64'h0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_accept && w_reject) || w_final_gnt;
            r_err   <= w_accept && w_reject;
            if (w_accept) begin
                r_word_addr <= st_addr_i[31:2];
                r_wide_be   <= w_wide_be;
                r_wide_d    <= w_wide_d;
            end
        end
    end

    // Request fields come straight from the latched store, so they cannot
    // change while a request waits for its grant; zero whenever idle.
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_addr_o  = 32'h0;
        dmem_be_o    = 4'h0;
        dmem_wdata_o = 32'h0;
        case (r_state)
            S_REQ_LO: begin
                dmem_req_o   = 1'b1;
                dmem_addr_o  = {r_word_addr, 2'b00};
                dmem_be_o    = r_wide_be[3:0];
                dmem_wdata_o = r_wide_d[31:0];
            end
            S_REQ_HI: begin
                dmem_req_o   = 1'b1;
                dmem_addr_o  = {w_word_addr_hi, 2'b00};
                dmem_be_o    = r_wide_be[7:4];
                dmem_wdata_o = r_wide_d[63:32];
            end
            default: ;
        endcase
    end

    assign dmem_we_o  = dmem_req_o;
    assign st_ready_o = (r_state == S_IDLE);
    assign busy_o     = !st_ready_o;
    assign st_done_o  = r_done;
    assign st_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_cntrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_store_cntrl
//  Description : Directed self-checking bench for store_cntrl. A second
//                instance with SPLIT_MISALIGNED=0 covers the reject path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_cntrl;

    logic        clk;
    logic        rst_n;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        st_done;
    logic        st_err;
    logic        busy;

    logic        st_valid0;
    logic        st_ready0;
    logic [31:0] st_addr0;
    logic [31:0] st_data0;
    logic [1:0]  st_size0;
    logic        dmem_req0;
    logic        dmem_gnt0;
    logic        dmem_we0;
    logic [31:0] dmem_addr0;
    logic [3:0]  dmem_be0;
    logic [31:0] dmem_wdata0;
    logic        st_done0;
    logic        st_err0;
    logic        busy0;

    int n_checks;
    int n_fail;

    store_cntrl #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .st_valid_i   (st_valid),
        .st_ready_o   (st_ready),
        .st_addr_i    (st_addr),
        .st_data_i    (st_data),
        .st_size_i    (st_size),
        .dmem_req_o   (dmem_req),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_be_o    (dmem_be),
        .dmem_wdata_o (dmem_wdata),
        .st_done_o    (st_done),
        .st_err_o     (st_err),
        .busy_o       (busy)
    );

    store_cntrl #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .st_valid_i   (st_valid0),
        .st_ready_o   (st_ready0),
        .st_addr_i    (st_addr0),
        .st_data_i    (st_data0),
        .st_size_i    (st_size0),
        .dmem_req_o   (dmem_req0),
        .dmem_gnt_i   (dmem_gnt0),
        .dmem_we_o    (dmem_we0),
        .dmem_addr_o  (dmem_addr0),
        .dmem_be_o    (dmem_be0),
        .dmem_wdata_o (dmem_wdata0),
        .st_done_o    (st_done0),
        .st_err_o     (st_err0),
        .busy_o       (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Request-side snapshot of the split-capable instance.
    task automatic check_req(input string tag, input logic req,
                             input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
        check({tag, ".req"},   {63'h0, dmem_req}, {63'h0, req});
        check({tag, ".we"},    {63'h0, dmem_we},  {63'h0, req});
        check({tag, ".addr"},  {32'h0, dmem_addr},  {32'h0, addr});
        check({tag, ".be"},    {60'h0, dmem_be},    {60'h0, be});
        check({tag, ".wdata"}, {32'h0, dmem_wdata}, {32'h0, wdata});
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        dmem_gnt  = 1'b0;
        dmem_gnt0 = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        st_valid0 = 1'b0;
        st_addr0  = 32'h0;
        st_data0  = 32'h0;
        st_size0  = 2'b00;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_req("rst", 1'b0, 32'h0, 4'h0, 32'h0);
        check("rst.ready", {63'h0, st_ready}, 64'h1);
        check("rst.busy",  {63'h0, busy},     64'h0);
        check("rst.done",  {63'h0, st_done},  64'h0);
        check("rst.err",   {63'h0, st_err},   64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- 1: SB 0x1003, grant in first req cycle ----------------
        drive(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check_req("t1.lo", 1'b1, 32'h0000_1000, 4'b1000, 32'hA500_0000);
        check("t1.busy",  {63'h0, busy},     64'h1);
        check("t1.ready", {63'h0, st_ready}, 64'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("t1.done",  {63'h0, st_done},  64'h1);
        check("t1.err",   {63'h0, st_err},   64'h0);
        check("t1.ready", {63'h0, st_ready}, 64'h1);
        check("t1.req_off", {63'h0, dmem_req}, 64'h0);

        // ---------------- 2: SW 0x2002, split, accepted in done cycle ----------------
        drive(1'b1, 32'h0000_2002, 32'h1122_3344, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("t2.done_clr", {63'h0, st_done}, 64'h0);
        check_req("t2.lo", 1'b1, 32'h0000_2000, 4'b1100, 32'h3344_0000);
        dmem_gnt = 1'b1;
        @(negedge clk);
        check_req("t2.hi", 1'b1, 32'h0000_2004, 4'b0011, 32'h0000_1122);
        check("t2.mid_done", {63'h0, st_done}, 64'h0);
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("t2.done", {63'h0, st_done}, 64'h1);
        check("t2.err",  {63'h0, st_err},  64'h0);
        check_req("t2.idle", 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("t2.done_pulse", {63'h0, st_done}, 64'h0);

        // ---------------- 3: SH 0x3001, grant withheld 5 cycles ----------------
        drive(1'b1, 32'h0000_3001, 32'h0000_BEEF, 2'b01);
        @(negedge clk);
        // inputs changing while busy must not disturb the held request
        drive(1'b1, 32'hDEAD_0000, 32'hFFFF_FFFF, 2'b10);
        for (int i = 0; i < 5; i++) begin
            check_req("t3.wait", 1'b1, 32'h0000_3000, 4'b0110, 32'h00BE_EF00);
            check("t3.busy", {63'h0, busy},    64'h1);
            check("t3.done", {63'h0, st_done}, 64'h0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check_req("t3.still", 1'b1, 32'h0000_3000, 4'b0110, 32'h00BE_EF00);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("t3.done_end", {63'h0, st_done}, 64'h1);
        check("t3.busy_end", {63'h0, busy},    64'h0);

        // ---------------- 4: SW 0xFFFFFFFE, address wrap ----------------
        drive(1'b1, 32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check_req("t4.lo", 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check_req("t4.hi", 1'b1, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
        @(negedge clk);
        check_req("t4.hi_hold", 1'b1, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("t4.done", {63'h0, st_done}, 64'h1);

        // ---------------- 5: rejection paths ----------------
        st_valid0 = 1'b1;
        st_addr0  = 32'h0000_4003;
        st_data0  = 32'h0000_1234;
        st_size0  = 2'b01;
        @(negedge clk);
        st_valid0 = 1'b0;
        check("t5a.req",   {63'h0, dmem_req0}, 64'h0);
        check("t5a.done",  {63'h0, st_done0},  64'h1);
        check("t5a.err",   {63'h0, st_err0},   64'h1);
        check("t5a.ready", {63'h0, st_ready0}, 64'h1);
        @(negedge clk);
        check("t5a.pulse", {62'h0, st_done0, st_err0}, 64'h0);
        check("t5a.req2",  {63'h0, dmem_req0}, 64'h0);

        drive(1'b1, 32'h0000_4100, 32'h5555_5555, 2'b11);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("t5b.req",  {63'h0, dmem_req}, 64'h0);
        check("t5b.done", {63'h0, st_done},  64'h1);
        check("t5b.err",  {63'h0, st_err},   64'h1);
        @(negedge clk);
        check("t5b.pulse", {62'h0, st_done, st_err}, 64'h0);
        check("t5b.req2",  {63'h0, dmem_req},        64'h0);

        // aligned half on the no-split instance still writes
        st_valid0 = 1'b1;
        st_addr0  = 32'h0000_4002;
        st_data0  = 32'h0000_ABCD;
        st_size0  = 2'b01;
        @(negedge clk);
        st_valid0 = 1'b0;
        check("t5c.req",   {63'h0, dmem_req0},   64'h1);
        check("t5c.addr",  {32'h0, dmem_addr0},  64'h0000_4000);
        check("t5c.be",    {60'h0, dmem_be0},    64'hC);
        check("t5c.wdata", {32'h0, dmem_wdata0}, 64'hABCD_0000);
        dmem_gnt0 = 1'b1;
        @(negedge clk);
        dmem_gnt0 = 1'b0;
        check("t5c.done", {62'h0, st_done0, st_err0}, 64'h2);

        // ---------------- 6: async reset while in REQ_HI ----------------
        drive(1'b1, 32'h0000_5001, 32'h8899_AABB, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check_req("t6.hi", 1'b1, 32'h0000_5004, 4'b0001, 32'h0000_0088);
        #2 rst_n = 1'b0;
        #1;
        check_req("t6.rst", 1'b0, 32'h0, 4'h0, 32'h0);
        check("t6.ready", {63'h0, st_ready}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_req("t6.no_hi", 1'b0, 32'h0, 4'h0, 32'h0);
        check("t6.no_done", {63'h0, st_done}, 64'h0);
        drive(1'b1, 32'h0000_6000, 32'h0000_0077, 2'b00);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check_req("t6.next", 1'b1, 32'h0000_6000, 4'b0001, 32'h0000_0077);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("t6.next_done", {62'h0, st_done, st_err}, 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
